song_sequencer: RTL

Synchronous song-line sequencer for the digital organ. It steps through an external song store of `{note[1:4], break}` lines, one line per quarter-note, and drives the per-note tone enables that gate the clock-synthesizer outputs. It replaces the free-running ripple metronome with a single-clock tempo prescaler, a start/stop/loop state machine and an end-of-song indication. It sits between the song ROM/RAM and the tone-gating AND stage at the organ top level.

---
 rtl/song_sequencer_pkg.sv | 33 +++
 rtl/song_sequencer_tick_divider.sv | 29 ++
 rtl/song_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/song_sequencer_pkg.sv
// Shared organ definitions: note codes, break flag, song line layout and
// sequencer state encoding.
package song_sequencer_pkg;

  localparam int SONG_LINE_BITS = 5;

  localparam logic [3:0] NOTE_C = 4'b1000;
  localparam logic [3:0] NOTE_D = 4'b0100;
  localparam logic [3:0] NOTE_E = 4'b0010;
  localparam logic [3:0] NOTE_G = 4'b0001;

  localparam logic HOLD  = 1'b0;
  localparam logic BREAK = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_PLAY  = 2'd3
  } seq_state_t;

  typedef logic [SONG_LINE_BITS-1:0] song_line_t;

  // A song line is {note[1:4], break}; note[1] (C) is the MSB.
  function automatic logic [3:0] line_notes(song_line_t line);
    return line[4:1];
  endfunction

  function automatic logic line_is_break(song_line_t line);
    return line[0] == BREAK;
  endfunction

endpackage

// File: rtl/song_sequencer_tick_divider.sv
// Synchronous modulo-DIVIDE counter; tick is high in the last count of each
// period. clear holds the count at zero.
module tick_divider #(
  parameter int DIVIDE = 7812
) (
  input  logic inclock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(DIVIDE);
  localparam logic [CW-1:0] LAST = CW'(DIVIDE - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == LAST);

  always_comb begin
    count_d = count_q + CW'(1);
    if (clear || tick) count_d = '0;
  end

  always_ff @(posedge inclock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/song_sequencer.sv
// Song-line sequencer: fetches {note[1:4], break} lines from a synchronous
// store, one line per 8 ticks, and gates the four tone enables.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int TICK_DIVIDE = 7812,
  parameter int SONG_LENGTH = 32,
  parameter int ADDR_BITS   = 5
) (
  input  logic                 inclock,
  input  logic                 reset,
  input  logic                 play,
  input  logic                 stop,
  input  logic                 loop,
  output logic [ADDR_BITS-1:0] songAddr,
  input  logic [4:0]           songData,
  output logic [3:0]           noteEnable,
  output logic                 playing,
  output logic                 lineStrobe,
  output logic                 songDone
);

  localparam logic [ADDR_BITS-1:0] LAST_INDEX = ADDR_BITS'(SONG_LENGTH - 1);

  seq_state_t           state_q, state_d;
  logic [ADDR_BITS-1:0] line_index_q, line_index_d;
  logic [2:0]           sub_step_q, sub_step_d;
  song_line_t           current_line_q, current_line_d;
  logic                 line_strobe_q, line_strobe_d;
  logic                 song_done_q, song_done_d;

  logic                 tick;
  logic                 last_line;
  logic                 line_end;
  logic [ADDR_BITS-1:0] next_index;
  logic                 mute;

  // Prescaler only runs in PLAY, so every line starts from a fresh count.
  tick_divider #(
    .DIVIDE (TICK_DIVIDE)
  ) u_tick (
    .inclock (inclock),
    .reset   (reset),
    .clear   (state_q != ST_PLAY),
    .tick    (tick)
  );

  assign last_line  = (line_index_q == LAST_INDEX);
  assign next_index = last_line ? '0 : line_index_q + ADDR_BITS'(1);
  assign line_end   = (state_q == ST_PLAY) && tick && (sub_step_q == 3'd7);

  always_comb begin
    state_d        = state_q;
    line_index_d   = line_index_q;
    sub_step_d     = sub_step_q;
    current_line_d = current_line_q;
    line_strobe_d  = 1'b0;
    song_done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        line_index_d = '0;
        if (play) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        current_line_d = songData;
        sub_step_d     = 3'd0;
        line_strobe_d  = 1'b1;
        state_d        = ST_PLAY;
      end
      ST_PLAY: begin
        if (tick) sub_step_d = sub_step_q + 3'd1;
        // songData already holds the prefetched next line at line end.
        if (line_end) begin
          if (last_line && !loop) begin
            state_d      = ST_IDLE;
            line_index_d = '0;
            song_done_d  = 1'b1;
          end else begin
            current_line_d = songData;
            line_index_d   = next_index;
            sub_step_d     = 3'd0;
            line_strobe_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (stop) begin
      state_d       = ST_IDLE;
      line_index_d  = '0;
      line_strobe_d = 1'b0;
      song_done_d   = 1'b0;
    end
  end

  always_ff @(posedge inclock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      line_index_q   <= '0;
      sub_step_q     <= '0;
      current_line_q <= '0;
      line_strobe_q  <= 1'b0;
      song_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      line_index_q   <= line_index_d;
      sub_step_q     <= sub_step_d;
      current_line_q <= current_line_d;
      line_strobe_q  <= line_strobe_d;
      song_done_q    <= song_done_d;
    end
  end

  always_comb begin
    songAddr = '0;
    case (state_q)
      ST_FETCH, ST_LOAD: songAddr = line_index_q;
      ST_PLAY:           songAddr = (sub_step_q == 3'd7) ? next_index : line_index_q;
      default:           songAddr = '0;
    endcase
  end

  assign mute       = line_is_break(current_line_q) && (sub_step_q == 3'd7);
  assign noteEnable = (state_q == ST_PLAY) ? (line_notes(current_line_q) & ~{4{mute}}) : 4'b0000;
  assign playing    = (state_q != ST_IDLE);
  assign lineStrobe = line_strobe_q;
  assign songDone   = song_done_q;

endmodule
